// File: rtl/ysyx_22040365_ifu.sv
// Non-pipelined instruction fetch unit: one outstanding imem request, delivers the fetched
// word and its PC to decode over a valid/ready channel and accepts PC redirects.
module ysyx_22040365_ifu #(
  parameter int unsigned       PC_W     = 64,
  parameter logic [PC_W-1:0]   RESET_PC = PC_W'(64'h0000_0000_8000_0000)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [PC_W-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rsp_data_i,
  input  logic            imem_rsp_err_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [31:0]     inst_o,
  output logic [PC_W-1:0] inst_pc_o,
  output logic            inst_fault_o,
  input  logic            redirect_valid_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  output logic [63:0]     fetch_cnt_o
);

  localparam logic [31:0] InstNop = 32'h0000_0013;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic [31:0]     inst_q, inst_d;
  logic [PC_W-1:0] inst_pc_q, inst_pc_d;
  logic            inst_fault_q, inst_fault_d;
  logic [63:0]     fetch_cnt_q, fetch_cnt_d;
  logic [PC_W-1:0] redirect_target;

  assign redirect_target = {redirect_pc_i[PC_W-1:2], 2'b00};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_fault_d = inst_fault_q;
    fetch_cnt_d  = fetch_cnt_q;
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (redirect_valid_i) pc_d = redirect_target;
        if (imem_req_ready_i) begin
          state_d = StWait;
          // The accepted request is for the old pc; its response must be discarded.
          drop_d  = redirect_valid_i;
        end
      end
      StWait: begin
        if (imem_rsp_valid_i) begin
          if (redirect_valid_i) begin
            pc_d    = redirect_target;
            drop_d  = 1'b0;
            state_d = StReq;
          end else if (drop_q) begin
            drop_d  = 1'b0;
            state_d = StReq;
          end else begin
            inst_d       = imem_rsp_err_i ? InstNop : imem_rsp_data_i;
            inst_pc_d    = pc_q;
            inst_fault_d = imem_rsp_err_i;
            state_d      = StHold;
          end
        end else if (redirect_valid_i) begin
          pc_d   = redirect_target;
          drop_d = 1'b1;
        end
      end
      StHold: begin
        if (redirect_valid_i) begin
          pc_d    = redirect_target;
          state_d = StReq;
        end else if (inst_ready_i) begin
          pc_d        = pc_q + PC_W'(4);
          fetch_cnt_d = fetch_cnt_q + 64'd1;
          state_d     = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_fault_q <= 1'b0;
      fetch_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_fault_q <= inst_fault_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  assign imem_req_valid_o = (state_q == StReq);
  assign imem_req_addr_o  = pc_q;
  assign inst_valid_o     = (state_q == StHold);
  assign inst_o           = inst_q;
  assign inst_pc_o        = inst_pc_q;
  assign inst_fault_o     = inst_fault_q;
  assign fetch_cnt_o      = fetch_cnt_q;

endmodule

// File: tb/tb_ysyx_22040365_ifu.sv
// Bench for the fetch unit: directed scenarios plus a randomized run against a
// transaction-level model of the delivered instruction stream.
module tb_ysyx_22040365_ifu;

  localparam logic [63:0] ResetPc = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready;
  logic [63:0] req_addr;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_fault;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [63:0] fetch_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_22040365_ifu #(.PC_W(64), .RESET_PC(ResetPc)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_req_valid_o (req_valid),
    .imem_req_ready_i (req_ready),
    .imem_req_addr_o  (req_addr),
    .imem_rsp_valid_i (rsp_valid),
    .imem_rsp_data_i  (rsp_data),
    .imem_rsp_err_i   (rsp_err),
    .inst_valid_o     (inst_valid),
    .inst_ready_i     (inst_ready),
    .inst_o           (inst),
    .inst_pc_o        (inst_pc),
    .inst_fault_o     (inst_fault),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .fetch_cnt_o      (fetch_cnt)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  function automatic logic mem_fault(input logic [63:0] a);
    return a[6:2] == 5'd7;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_ready = 0; rsp_valid = 0; rsp_err = 0; rsp_data = '0;
    inst_ready = 0; redirect_valid = 0; redirect_pc = '0;
  endtask

  // Leaves the DUT in REQ with pc = reset pc.
  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    tick();
  endtask

  // From REQ: zero-wait request then response; leaves the DUT in HOLD.
  task automatic fetch_to_hold(input logic [31:0] data, input logic err);
    req_ready = 1; tick(); req_ready = 0;
    rsp_valid = 1; rsp_data = data; rsp_err = err; tick();
    rsp_valid = 0; rsp_err = 0;
  endtask

  task automatic consume();
    inst_ready = 1; tick(); inst_ready = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    repeat (3) tick();
    checks++;
    if (req_valid !== 0 || inst_valid !== 0 || inst !== 0 || inst_pc !== 0 || inst_fault !== 0 ||
        fetch_cnt !== 0 || req_addr !== ResetPc) begin
      failures++;
      $display("FAIL reset_state: rv=%b iv=%b inst=%h ipc=%h flt=%b cnt=%0d addr=%h, want all 0 addr=%h",
               req_valid, inst_valid, inst, inst_pc, inst_fault, fetch_cnt, req_addr, ResetPc);
    end
    rst_n = 1;
    checks++;
    if (req_valid !== 0) begin failures++; $display("FAIL cycle0_req: got %b want 0", req_valid); end
    tick();
    checks++;
    if (req_valid !== 1 || req_addr !== ResetPc) begin
      failures++; $display("FAIL first_req: rv=%b addr=%h want 1 %h", req_valid, req_addr, ResetPc);
    end
    fetch_to_hold(32'h0010_0093, 0);
    checks++;
    if (inst_valid !== 1 || inst !== 32'h0010_0093 || inst_pc !== ResetPc || inst_fault !== 0) begin
      failures++;
      $display("FAIL first_inst: iv=%b inst=%h pc=%h flt=%b want 1 00100093 %h 0",
               inst_valid, inst, inst_pc, inst_fault, ResetPc);
    end
  endtask

  task automatic test_stream();
    logic [63:0] pc;
    do_reset();
    req_ready = 1; inst_ready = 1;
    for (int k = 0; k < 4; k++) begin
      pc = ResetPc + 64'(4 * k);
      checks++;
      if (req_valid !== 1 || inst_valid !== 0 || req_addr !== pc) begin
        failures++; $display("FAIL stream_req%0d: rv=%b iv=%b addr=%h want 1 0 %h",
                             k, req_valid, inst_valid, req_addr, pc);
      end
      tick();
      checks++;
      if (inst_valid !== 0 || req_valid !== 0) begin
        failures++; $display("FAIL stream_wait%0d: iv=%b rv=%b want 0 0", k, inst_valid, req_valid);
      end
      rsp_valid = 1; rsp_data = mem_word(pc); tick(); rsp_valid = 0;
      checks++;
      if (inst_valid !== 1 || inst_pc !== pc || inst !== mem_word(pc)) begin
        failures++; $display("FAIL stream_hold%0d: iv=%b pc=%h inst=%h want 1 %h %h",
                             k, inst_valid, inst_pc, inst, pc, mem_word(pc));
      end
      tick();
    end
    req_ready = 0; inst_ready = 0;
    checks++;
    if (fetch_cnt !== 64'd4) begin
      failures++; $display("FAIL stream_cnt: got %0d want 4", fetch_cnt);
    end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (req_valid !== 1 || req_addr !== ResetPc + 64'h10) begin
        failures++; $display("FAIL req_stall%0d: rv=%b addr=%h want 1 %h",
                             k, req_valid, req_addr, ResetPc + 64'h10);
      end
    end
    fetch_to_hold(32'hCAFE_0013, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (inst_valid !== 1 || inst !== 32'hCAFE_0013 || inst_pc !== ResetPc + 64'h10 ||
          req_valid !== 0 || fetch_cnt !== 64'd4) begin
        failures++; $display("FAIL hold_stall%0d: iv=%b inst=%h pc=%h rv=%b cnt=%0d",
                             k, inst_valid, inst, inst_pc, req_valid, fetch_cnt);
      end
    end
    consume();
    checks++;
    if (req_valid !== 1 || req_addr !== ResetPc + 64'h14 || fetch_cnt !== 64'd5) begin
      failures++; $display("FAIL hold_release: rv=%b addr=%h cnt=%0d want 1 %h 5",
                           req_valid, req_addr, fetch_cnt, ResetPc + 64'h14);
    end
  endtask

  task automatic test_redirect_wait();
    req_ready = 1; tick(); req_ready = 0;
    redirect_valid = 1; redirect_pc = 64'h8000_1002; tick(); redirect_valid = 0;
    rsp_valid = 1; rsp_data = 32'hDEAD_BEEF; tick(); rsp_valid = 0;
    checks++;
    if (inst_valid !== 0 || req_valid !== 1 || req_addr !== 64'h8000_1000) begin
      failures++; $display("FAIL redir_wait_drop: iv=%b rv=%b addr=%h want 0 1 80001000",
                           inst_valid, req_valid, req_addr);
    end
    fetch_to_hold(32'h1111_2222, 0);
    checks++;
    if (inst_valid !== 1 || inst_pc !== 64'h8000_1000 || inst !== 32'h1111_2222) begin
      failures++; $display("FAIL redir_wait_deliver: iv=%b pc=%h inst=%h want 1 80001000 11112222",
                           inst_valid, inst_pc, inst);
    end
    consume();
    req_ready = 1; tick(); req_ready = 0;
    redirect_valid = 1; redirect_pc = 64'h8000_2000; rsp_valid = 1; tick();
    redirect_valid = 0; rsp_valid = 0;
    checks++;
    if (inst_valid !== 0 || req_valid !== 1 || req_addr !== 64'h8000_2000) begin
      failures++; $display("FAIL redir_rsp_same: iv=%b rv=%b addr=%h want 0 1 80002000",
                           inst_valid, req_valid, req_addr);
    end
    fetch_to_hold(32'h3333_4444, 0);
    checks++;
    if (inst_valid !== 1 || inst_pc !== 64'h8000_2000) begin
      failures++; $display("FAIL no_drop_carry: iv=%b pc=%h want 1 80002000", inst_valid, inst_pc);
    end
  endtask

  task automatic test_redirect_hold();
    inst_ready = 1; redirect_valid = 1; redirect_pc = 64'h8000_3000; tick();
    inst_ready = 0; redirect_valid = 0;
    checks++;
    if (inst_valid !== 0 || fetch_cnt !== 64'd6 || req_valid !== 1 || req_addr !== 64'h8000_3000) begin
      failures++; $display("FAIL redir_hold: iv=%b cnt=%0d rv=%b addr=%h want 0 6 1 80003000",
                           inst_valid, fetch_cnt, req_valid, req_addr);
    end
  endtask

  task automatic test_redirect_req();
    redirect_valid = 1; redirect_pc = 64'h8000_4001; tick(); redirect_valid = 0;
    checks++;
    if (req_valid !== 1 || req_addr !== 64'h8000_4000) begin
      failures++; $display("FAIL redir_req_noready: rv=%b addr=%h want 1 80004000", req_valid, req_addr);
    end
    redirect_valid = 1; redirect_pc = 64'h8000_5000; req_ready = 1; tick();
    redirect_valid = 0; req_ready = 0;
    rsp_valid = 1; tick(); rsp_valid = 0;
    checks++;
    if (inst_valid !== 0 || req_valid !== 1 || req_addr !== 64'h8000_5000) begin
      failures++; $display("FAIL redir_req_ready: iv=%b rv=%b addr=%h want 0 1 80005000",
                           inst_valid, req_valid, req_addr);
    end
  endtask

  task automatic test_fault();
    do_reset();
    fetch_to_hold(32'h0000_1111, 0); consume();
    fetch_to_hold(32'h0000_2222, 0); consume();
    fetch_to_hold(32'hFFFF_FFFF, 1);
    checks++;
    if (inst !== 32'h0000_0013 || inst_fault !== 1 || inst_pc !== ResetPc + 64'h8) begin
      failures++; $display("FAIL fault_deliver: inst=%h flt=%b pc=%h want 00000013 1 %h",
                           inst, inst_fault, inst_pc, ResetPc + 64'h8);
    end
    consume();
    checks++;
    if (req_valid !== 1 || req_addr !== ResetPc + 64'hC) begin
      failures++; $display("FAIL fault_next_req: rv=%b addr=%h", req_valid, req_addr);
    end
    fetch_to_hold(32'h0000_4444, 0);
    checks++;
    if (inst !== 32'h0000_4444 || inst_fault !== 0 || inst_pc !== ResetPc + 64'hC) begin
      failures++; $display("FAIL fault_after: inst=%h flt=%b pc=%h want 00004444 0 %h",
                           inst, inst_fault, inst_pc, ResetPc + 64'hC);
    end
    consume();
  endtask

  task automatic test_async_reset();
    req_ready = 1; tick(); req_ready = 0;
    #2 rst_n = 0;
    #1;
    checks++;
    if (req_valid !== 0 || inst_valid !== 0 || inst !== 0 || inst_pc !== 0 || inst_fault !== 0 ||
        fetch_cnt !== 0 || req_addr !== ResetPc) begin
      failures++; $display("FAIL async_reset: rv=%b iv=%b inst=%h pc=%h cnt=%0d addr=%h",
                           req_valid, inst_valid, inst, inst_pc, fetch_cnt, req_addr);
    end
    tick();
    rst_n = 1; rsp_valid = 1; rsp_data = 32'hBAD0_BAD0;
    tick(); tick();
    rsp_valid = 0;
    checks++;
    if (req_valid !== 1 || inst_valid !== 0 || req_addr !== ResetPc) begin
      failures++; $display("FAIL late_rsp_ignored: rv=%b iv=%b addr=%h want 1 0 %h",
                           req_valid, inst_valid, req_addr, ResetPc);
    end
    fetch_to_hold(32'h0000_5555, 0);
    checks++;
    if (inst_valid !== 1 || inst_pc !== ResetPc || inst !== 32'h0000_5555) begin
      failures++; $display("FAIL restart: iv=%b pc=%h inst=%h", inst_valid, inst_pc, inst);
    end
  endtask

  // Model: the next instruction decode sees is at the latest redirect target, else
  // one word past the last one consumed; its content comes from the memory image.
  task automatic test_random();
    logic [63:0] exp_pc, exp_cnt, pend_addr, tgt, prev_pc;
    logic [31:0] prev_inst;
    bit          pending, prev_stall;
    int unsigned wait_c;
    int          errs_before;
    do_reset();
    exp_pc = ResetPc; exp_cnt = 0; pending = 0; prev_stall = 0; wait_c = 0;
    pend_addr = '0; prev_pc = '0; prev_inst = '0;
    errs_before = failures;
    for (int c = 0; c < 4000 && failures - errs_before < 10; c++) begin
      checks++;
      if (fetch_cnt !== exp_cnt) begin
        failures++; $display("FAIL rand_cnt c=%0d: got %0d want %0d", c, fetch_cnt, exp_cnt);
      end
      if (req_valid) begin
        checks++;
        if (req_addr !== exp_pc) begin
          failures++; $display("FAIL rand_addr c=%0d: got %h want %h", c, req_addr, exp_pc);
        end
      end
      if (inst_valid) begin
        checks++;
        if (inst_pc !== exp_pc || inst_fault !== mem_fault(exp_pc) ||
            inst !== (mem_fault(exp_pc) ? 32'h0000_0013 : mem_word(exp_pc))) begin
          failures++; $display("FAIL rand_inst c=%0d: pc=%h inst=%h flt=%b want pc=%h", c,
                               inst_pc, inst, inst_fault, exp_pc);
        end
      end
      if (prev_stall) begin
        checks++;
        if (inst_valid !== 1 || inst_pc !== prev_pc || inst !== prev_inst) begin
          failures++; $display("FAIL rand_stable c=%0d: iv=%b pc=%h inst=%h want 1 %h %h", c,
                               inst_valid, inst_pc, inst, prev_pc, prev_inst);
        end
      end
      redirect_valid = ($urandom_range(0, 15) == 0);
      tgt = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_3fff)};
      redirect_pc = tgt;
      inst_ready = 1'($urandom_range(0, 1));
      req_ready = ($urandom_range(0, 4) < 3);
      rsp_valid = 0; rsp_err = 0; rsp_data = $urandom;
      if (pending) begin
        if (wait_c == 0) begin
          rsp_valid = 1; rsp_data = mem_word(pend_addr); rsp_err = mem_fault(pend_addr);
          pending = 0;
        end else begin
          wait_c--;
        end
      end
      if (req_valid && req_ready) begin
        pending = 1; pend_addr = req_addr; wait_c = $urandom_range(0, 2);
      end
      prev_stall = inst_valid && !inst_ready && !redirect_valid;
      prev_pc = exp_pc;
      prev_inst = mem_fault(exp_pc) ? 32'h0000_0013 : mem_word(exp_pc);
      if (redirect_valid) begin
        exp_pc = tgt & ~64'h3;
      end else if (inst_valid && inst_ready) begin
        exp_pc = exp_pc + 64'd4;
        exp_cnt = exp_cnt + 64'd1;
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_hold();
    test_redirect_req();
    test_fault();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
